// File: rtl/sram_frame_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_frame_arbiter_pkg
// Brief    : Shared SRAM bus types, frame geometry and arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package sram_frame_arbiter_pkg;

  localparam int C_ADDR_W   = 20;
  localparam int C_DATA_W   = 32;
  localparam int C_H_ACTIVE = 640;
  localparam int C_V_ACTIVE = 480;
  localparam int C_FRAME_WORDS = C_H_ACTIVE * C_V_ACTIVE;

  // The back buffer sits exactly one frame above the front buffer.
  localparam logic [C_ADDR_W-1:0] C_BASE0 = 20'h00000;
  localparam logic [C_ADDR_W-1:0] C_BASE1 = C_BASE0 + C_ADDR_W'(C_FRAME_WORDS);

  typedef struct packed {
    logic [C_ADDR_W-1:0] addr;
    logic [C_DATA_W-1:0] dout;
    logic                oe_n;
    logic                we_n;
    logic                den;
  } SramRequest_t;

  typedef struct packed {
    logic [C_DATA_W-1:0] din;
    logic                done;
  } SramResult_t;

  typedef struct packed {
    logic [C_ADDR_W-1:0] offset;
    logic [C_DATA_W-1:0] data;
  } SramWriteEntry_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_frame_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_frame_arbiter_if
// Brief    : Client-side and SRAM-side bus bundle of the frame arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_frame_arbiter_if #(
  parameter int DEPTH = 16
);
  import sram_frame_arbiter_pkg::*;

  SramRequest_t            vgaReq;
  SramResult_t             vgaResult;
  logic                    wrValid;
  logic                    wrReady;
  logic [C_ADDR_W-1:0]     wrOffset;
  logic [C_DATA_W-1:0]     wrData;
  logic                    swapReq;
  logic                    swapAck;
  logic                    paintDone;
  logic [C_ADDR_W-1:0]     displayBase;
  logic [C_ADDR_W-1:0]     drawBase;
  SramRequest_t            ramRequest;
  SramResult_t             ramResult;
  logic [$clog2(DEPTH):0]  fifoLevel;

  // master: display adapter, renderer and SRAM controller side
  modport master (
    output vgaReq, wrValid, wrOffset, wrData, swapReq, paintDone, ramResult,
    input  vgaResult, wrReady, swapAck, displayBase, drawBase, ramRequest, fifoLevel
  );

  // slave: the arbiter itself
  modport slave (
    input  vgaReq, wrValid, wrOffset, wrData, swapReq, paintDone, ramResult,
    output vgaResult, wrReady, swapAck, displayBase, drawBase, ramRequest, fifoLevel
  );

endinterface
`default_nettype wire

// File: rtl/sram_frame_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sram_write_fifo
// Brief    : Synchronous FIFO of pending renderer writes with level/full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module sram_write_fifo
  import sram_frame_arbiter_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_push,
  input  wire SramWriteEntry_t        i_entry,
  input  wire logic                   i_pop,
  output SramWriteEntry_t             o_head,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(DEPTH):0]      o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  SramWriteEntry_t    r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_level;

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/sram_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_frame_arbiter
// Brief    : Shares the framebuffer SRAM between VGA scan-out (priority) and a
//            FIFO-buffered renderer write stream; swaps buffers in blanking.
// Revision : 1.0 - initial release
// ============================================================================
module sram_frame_arbiter
  import sram_frame_arbiter_pkg::*;
#(
  parameter int                ADDR_W = C_ADDR_W,
  parameter int                DATA_W = C_DATA_W,
  parameter int                DEPTH  = 16,
  parameter logic [ADDR_W-1:0] BASE0  = C_BASE0,
  parameter logic [ADDR_W-1:0] BASE1  = C_BASE1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  sram_frame_arbiter_if.slave  bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic                r_swap_pending;
  logic                r_swap_ack;
  logic [ADDR_W-1:0]   r_display_base;
  logic [ADDR_W-1:0]   r_draw_base;

  SramWriteEntry_t     w_push_entry;
  SramWriteEntry_t     w_head;
  logic [ADDR_W-1:0]   w_wr_offset;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_full;
  logic                w_empty;
  logic [LVL_W-1:0]    w_level;
  logic                w_wr_ready;
  logic                w_push;
  logic                w_pop;
  logic                w_vga_own;
  logic                w_wr_own;
  logic                w_swap_fire;
  SramRequest_t        w_ram_req;
  SramResult_t         w_vga_res;

  assign w_wr_offset  = bus.wrOffset;
  assign w_wr_data    = bus.wrData;
  assign w_push_entry = '{offset: w_wr_offset, data: w_wr_data};

  // Ready depends on registered state only: full comes from the FIFO level register.
  assign w_wr_ready  = !w_full && !r_swap_pending;
  assign w_push      = bus.wrValid && w_wr_ready;
  assign w_vga_own   = !bus.vgaReq.oe_n;
  assign w_wr_own    = !w_vga_own && (r_state == ST_WRITE);
  assign w_pop       = w_wr_own && bus.ramResult.done;
  assign w_swap_fire = r_swap_pending && bus.paintDone && w_empty && (r_state == ST_IDLE);

  sram_write_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_pop && (w_level == LVL_W'(1)) && !w_push) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // A preempted write simply keeps the head in place and re-presents it later.
  always_comb begin
    w_ram_req      = '0;
    w_ram_req.oe_n = 1'b1;
    w_ram_req.we_n = 1'b1;
    w_ram_req.den  = 1'b0;
    w_vga_res      = '0;
    if (w_vga_own) begin
      w_ram_req      = bus.vgaReq;
      w_ram_req.we_n = 1'b1;
      w_ram_req.den  = 1'b0;
      w_vga_res      = bus.ramResult;
    end else if (r_state == ST_WRITE) begin
      w_ram_req.addr = r_draw_base + w_head.offset;
      w_ram_req.dout = w_head.data;
      w_ram_req.oe_n = 1'b1;
      w_ram_req.we_n = 1'b0;
      w_ram_req.den  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_swap_pending <= 1'b0;
      r_swap_ack     <= 1'b0;
      r_display_base <= BASE0;
      r_draw_base    <= BASE1;
    end else begin
      r_swap_ack <= w_swap_fire;
      if (w_swap_fire) begin
        r_swap_pending <= 1'b0;
        r_display_base <= r_draw_base;
        r_draw_base    <= r_display_base;
      end else if (bus.swapReq) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  assign bus.ramRequest  = w_ram_req;
  assign bus.vgaResult   = w_vga_res;
  assign bus.wrReady     = w_wr_ready;
  assign bus.swapAck     = r_swap_ack;
  assign bus.displayBase = r_display_base;
  assign bus.drawBase    = r_draw_base;
  assign bus.fifoLevel   = w_level;

endmodule
`default_nettype wire

// File: doc/sram_frame_arbiter.md
Name: sram_frame_arbiter

Overview:
- Shares the single framebuffer SRAM between the VGA scan-out reader and the pixel renderer's write stream.
- Manages double-buffered base addresses: front buffer for display, back buffer for drawing.
- Sits between the display adapter / renderer and the SRAM controller.
- VGA reads have absolute priority. Renderer writes are buffered in a FIFO and drained whenever the VGA reader is idle. Buffer swaps occur only during vertical blank.

Parameters:
- ADDR_W, 20, SRAM word address width (matches SramAddress_t).
- DATA_W, 32, SRAM data width (matches SramResult_t.din).
- DEPTH, 16, write FIFO entries; power of two, at least 2.
- BASE0, 20'h00000, reset value of displayBase.
- BASE1, 20'h4B000, reset value of drawBase (640*480 words above BASE0).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- vgaReq  in  SramRequest_t  read request from the display adapter.
- vgaResult  out  SramResult_t  result returned to the display adapter.
- wrValid  in  1  renderer write valid.
- wrReady  out  1  write accepted when wrValid & wrReady.
- wrOffset  in  ADDR_W  pixel offset relative to drawBase.
- wrData  in  DATA_W  pixel word.
- swapReq  in  1  one-cycle pulse: the frame is complete, swap at the next blank.
- swapAck  out  1  one-cycle pulse on the cycle the swap takes effect.
- paintDone  in  1  high while the display is in vertical blank.
- displayBase  out  ADDR_W  base address fed to the display adapter.
- drawBase  out  ADDR_W  base address of the back buffer.
- ramRequest  out  SramRequest_t  to the SRAM controller.
- ramResult  in  SramResult_t  from the SRAM controller.
- fifoLevel  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset values:
- On rst high (async): FIFO empty, fifoLevel=0, state IDLE, swapPending=0, swapAck=0.
- displayBase=BASE0, drawBase=BASE1.
- ramRequest is idle: oe_n=1, we_n=1, den=0.
- vgaResult.done=0.

Ownership (combinational each cycle):
- If vgaReq.oe_n==0, VGA owns the bus.
  - ramRequest = vgaReq, with we_n and den forced to 1 and 0.
  - vgaResult = ramResult.
- Otherwise, if the state is WRITE, the writer owns the bus.
  - address = drawBase + head.offset (modulo 2^ADDR_W).
  - we_n=0, oe_n=1, den=1, data = head.data.
  - vgaResult.done=0.
- Otherwise the bus is idle: oe_n=1, we_n=1, den=0.

Write FSM:
- IDLE -> WRITE when the FIFO is non-empty.
- WRITE -> IDLE when ramResult.done is seen in a cycle the writer owned the bus. Pop the head on that same edge.
- VGA preemption during WRITE: no pop, the request is withheld that cycle, and it is re-presented unchanged once VGA releases. A write is never lost or duplicated.
- WRITE may chain directly to WRITE (pop and start the next entry) when the FIFO still holds entries after the pop.

FIFO:
- wrReady = !full & !swapPending, computed from registers only (no combinational path from wrValid).
- Push when wrValid & wrReady. Push and pop on the same edge are both performed and fifoLevel is unchanged.
- Pointers wrap modulo DEPTH. wrValid while not ready is ignored; no data is captured.

Swap:
- swapReq sets swapPending. A swapReq while already pending is ignored (no double swap).
- Swap fires on the first edge where swapPending & paintDone & FIFO empty & state IDLE. On that edge:
  - displayBase and drawBase exchange values.
  - swapPending clears.
  - swapAck pulses high for exactly one cycle.
- If paintDone falls before the FIFO drains, the swap waits for the next blank.
- wrReady stays 0 from swapReq through swapAck, so back-buffer writes cannot straddle a swap.

Reset mid-operation: in-flight writes and FIFO contents are discarded, and bases return to their reset values.

Decomposition:
- DataType.sv: add SramWriteEntry_t {offset ADDR_W, data DATA_W} and an arbiter state enum {IDLE, WRITE}.
- Frame constants (H_ACTIVE*V_ACTIVE = 307200 words) move into a shared localparam set so BASE1 derives from them.
- Sub-module: sram_write_fifo (synchronous FIFO of SramWriteEntry_t, DEPTH entries, full/empty/level outputs, async active-high reset).

Test Plan:
1. Reset, then idle -> displayBase=20'h00000, drawBase=20'h4B000, wrReady=1, fifoLevel=0, ramRequest.oe_n=1, ramRequest.we_n=1.
2. Push 3 writes (offsets 0,1,2; data 32'hA,B,C) with vgaReq idle and SRAM done asserted 1 cycle after each request -> ramRequest shows we_n=0 at addresses 4B000, 4B001, 4B002 in order; fifoLevel ends at 0.
3. Hold vgaReq.oe_n=0 continuously while pushing 16 writes -> no we_n=0 ever; fifoLevel=16; wrReady=0; a 17th push is not captured. Release VGA -> all 16 writes drain in order.
4. Assert vgaReq.oe_n=0 during a WRITE before done -> VGA address appears on ramRequest that cycle and the pending write is re-issued afterwards with identical address/data; no write is skipped or repeated.
5. swapReq with paintDone=0 -> wrReady=0, no swap. Raise paintDone with the FIFO empty -> swapAck one cycle high, displayBase=4B000, drawBase=00000. A second swapReq plus blank swaps them back.
6. swapReq with 4 entries queued and paintDone high for 2 cycles only -> swap deferred; swapAck occurs in the next paintDone window after the FIFO drains. Assert rst mid-WRITE -> fifoLevel=0 and bases reset.
